// File: rtl/gcd_bcd_conv.sv
// gcd_bcd_conv
// ------------
// Sequential binary-to-BCD converter placed behind the subtractive GCD unit.
// A finished binary result is captured on the accepting edge and converted
// with shift-and-add-3 (double dabble), one bit per clock. The packed BCD
// digits are then held for the readout stage until the consumer takes them.
//
// Optional feature macro: GCD_BCD_BLANK_EN
//   defined   -> blank_o flags leading-zero digits (digit 0 never blanked)
//   undefined -> blank_o is tied to zero and no blanking logic exists
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready_o/out_valid_o are decoded from the
// registered state only, so neither depends combinationally on any input.
// in_valid_i is ignored outside IDLE; bin_i is sampled only on the
// accepting edge.
//
// Ports
//   clk_i        system clock, all state on the rising edge
//   rst_i        synchronous active-high reset, overrides everything
//   in_valid_i   bin_i holds a finished result (GCD fin)
//   in_ready_o   converter idle, accepts on this edge
//   bin_i        unsigned binary value, WIDTH bits (GCD o)
//   out_valid_o  bcd_o/blank_o hold a finished conversion
//   out_ready_i  consumer takes the result
//   bcd_o        packed BCD, bcd_o[3:0] is the least significant digit
//   blank_o      per-digit leading-zero blank flags
//   state_o      current FSM state (IDLE=0, SHIFT=1, DONE=2) for debug
//
// Parameters: WIDTH (16), DIGITS (5); 10**DIGITS must exceed 2**WIDTH so no
// nibble ever exceeds 9 after a shift.

module gcd_bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o,
    output logic [1:0]            state_o
);

    localparam int WR = 4*DIGITS + WIDTH;     // working register width
    localparam int CW = $clog2(WIDTH + 1);    // bit counter width

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WR-1:0]       work_q, work_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;

    logic [WR-1:0]       adj_w;
    logic [WR-1:0]       shifted_w;
    logic                finish_w;

    // Add-3 correction on every BCD nibble >= 5, then one left shift.
    // The binary part sits in the low WIDTH bits and is shifted up into
    // the BCD part one bit per cycle.
    always_comb begin
        adj_w = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[WIDTH+4*i +: 4] >= 4'd5) begin
                adj_w[WIDTH+4*i +: 4] = work_q[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        shifted_w = adj_w << 1;
    end

    // Last shift of the conversion: the BCD part of shifted_w is final.
    assign finish_w = (state_q == S_SHIFT) && (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    work_d  = {{(4*DIGITS){1'b0}}, bin_i};
                    cnt_d   = CW'(WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = shifted_w;
                cnt_d  = cnt_q - CW'(1);
                if (finish_w) begin
                    state_d = S_DONE;
                    bcd_d   = shifted_w[WR-1 -: 4*DIGITS];
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
        end
    end

`ifdef GCD_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;

    // blank[i] is set when digit i and every digit above it are zero;
    // digit 0 always stays visible.
    function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'd0);
            b[i] = z;
        end
        return b;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blank_q <= '0;
        end else if (finish_w) begin
            blank_q <= blank_of(shifted_w[WR-1 -: 4*DIGITS]);
        end
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign bcd_o       = bcd_q;
    assign state_o     = state_q;

endmodule

// File: doc/gcd_bcd_conv.md
# gcd_bcd_conv

Sequential binary-to-BCD converter sitting directly downstream of the subtractive GCD unit. It captures the unit's binary result when `fin` is presented as `in_valid`, converts it to packed BCD by shift-and-add-3 (double dabble), one bit per clock, and holds the digits for the display/readout stage under a valid/ready handshake. Optional leading-zero blanking feeds seven-segment drivers directly.

## Interface
- `WIDTH`, 16: binary input width.
- `DIGITS`, 5: BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid`  in  1  `bin` holds a finished result (wired to GCD `fin`).
- `in_ready`  out  1  converter idle, will accept on this edge.
- `bin`  in  WIDTH  unsigned binary value (wired to GCD `o`).
- `out_valid`  out  1  `bcd`/`blank` hold a finished conversion.
- `out_ready`  in  1  consumer takes the result.
- `bcd`  out  4*DIGITS  packed BCD; `bcd[3:0]` is the least significant digit.
- `blank`  out  DIGITS  per-digit leading-zero blank flags; bit i refers to digit i.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1, `out_valid`=0. On `in_valid`=1: capture `bin` into the low part of a (4*DIGITS+WIDTH)-bit working register, clear the BCD part, load the bit counter with WIDTH, go to SHIFT.
- `bin` is sampled only on the accepting edge; later changes are ignored.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole working register left by 1 and decrement the counter. After the WIDTH-th shift, go to DONE and latch the BCD part into `bcd`.
- DONE: `out_valid`=1, `in_ready`=0. `bcd` and `blank` are stable. On `out_ready`=1, go to IDLE. `in_valid` is ignored in SHIFT and DONE.
- The GCD `fin` stays high while its result is stable. A new pair is therefore taken only after the previous result has been consumed and the converter is back in IDLE. The same result is re-converted if `fin` is still high then; the upstream controller pulses `init` to advance.
- All nibble compares and adds are 4-bit unsigned. No nibble exceeds 9 after a shift when the `DIGITS` rule holds.
- Reset: state IDLE, counter 0, working register 0. Outputs after reset: `bcd`=0, `blank`=0, `out_valid`=0, `in_ready`=1.
- `rst` overrides every other input in every state. Reset mid-SHIFT or in DONE abandons the conversion with no partial output.

## Timing
- The accepting edge is the edge where `in_valid` and `in_ready` are both 1; state goes to SHIFT.
- Shift edges follow, WIDTH of them. `out_valid` goes high after the WIDTH-th edge following acceptance: 16 cycles at default.
- Result transfer happens on the edge where `out_valid` and `out_ready` are both 1. `out_valid` and `in_ready` change on the next cycle.
- Minimum initiation interval is WIDTH+2 cycles, with `out_ready` held at 1.
- `in_ready` and `out_valid` are decoded from the registered state only, with no combinational path from inputs. `bcd` and `blank` are registered.

## Configuration
- `GCD_BCD_BLANK_EN` defined:
  - `blank[i]`=1 when digit i and every digit above it are zero.
  - Digit 0 is never blanked.
  - `blank` is registered together with `bcd` on entry to DONE.
- `GCD_BCD_BLANK_EN` undefined: `blank` is tied to all zeros and no blanking logic is built. Everything else is identical.

## Test plan
- Reset, then `bin`=0 with `in_valid`=1 → after 16 cycles `out_valid`=1, `bcd`=20'h00000, `blank`=5'b11110 (00000 without macro).
- `bin`=16'd65535 → `bcd`=20'h65535, `blank`=0. `out_valid` rises exactly 16 edges after acceptance; `in_ready`=0 throughout.
- `bin`=16'd1234 → `bcd`=20'h01234, `blank`=5'b10000 with macro.
- Hold `out_ready`=0 for 10 cycles in DONE while toggling `in_valid`/`bin` → `bcd`, `out_valid`=1 and `in_ready`=0 unchanged. Set `out_ready`=1 → IDLE on the next cycle.
- Assert `rst` on the 7th SHIFT cycle → next cycle IDLE, `out_valid`=0, `bcd`=0. Then `bin`=99 → `bcd`=20'h00099.
- Connect GCD unit (a=48, b=18): when `fin` rises → `bcd`=20'h00006. Then GCD a=1071, b=462 → `bcd`=20'h00021.
